cwe1234_lock_arbiter: RTL and testbench

CWE1234_LOCK_ARBITER -- requirements
Module: cwe1234_lock_arbiter

---
 rtl/cwe1234_lock_arbiter.sv | 138 +++++++++++++
 tb/tb_cwe1234_lock_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cwe1234_lock_arbiter.sv
// Two-requester arbiter guarding a lockable shared 16-bit register.
// Once locked, writes are rejected until reset. A keyed debug override
// that opens a bounded write window exists only when CWE1234_DBG_UNLOCK_EN
// is defined; otherwise the lock is absolute.
module cwe1234_lock_arbiter #(
    parameter logic [15:0] KEY        = 16'hA5C3,
    parameter logic [7:0]  DBG_WINDOW = 8'd16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_1_i,
    input  logic        req_2_i,
    input  logic [15:0] data_1_i,
    input  logic [15:0] data_2_i,
    output logic        ack_1_o,
    output logic        ack_2_o,
    output logic        err_1_o,
    output logic        err_2_o,
    input  logic        lock_req_i,
    output logic        lock_status_o,
    input  logic        dbg_unlock_req_i,
    input  logic [15:0] dbg_key_i,
    output logic        dbg_active_o,
    output logic        dbg_fail_o,
    output logic [15:0] data_out_o,
    output logic        last_grant_o
);

    typedef enum logic [1:0] {StIdle, StGrant, StResp} state_e;

    state_e      state_q;
    logic        last_grant_q;
    logic        lock_q;
    logic        ack_1_q, ack_2_q, err_1_q, err_2_q;
    logic [15:0] data_q;
    logic        dbg_active_q;
    logic        dbg_fail_q;

    logic        win_d;
    logic        blocked_d;
    logic [15:0] win_data_d;

    // Arbitration winner and write-blocking decision for the current cycle.
    always_comb begin
        win_d = last_grant_q;
        if (req_1_i && req_2_i) begin
            win_d = ~last_grant_q;
        end else if (req_2_i) begin
            win_d = 1'b1;
        end else if (req_1_i) begin
            win_d = 1'b0;
        end
        // A lock request in the same cycle as the write already wins.
        blocked_d  = (lock_q | lock_req_i) & ~dbg_active_q;
        win_data_d = last_grant_q ? data_2_i : data_1_i;
    end

    // Transaction FSM with registered responses, protected data and sticky lock.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            lock_q       <= 1'b0;
            ack_1_q      <= 1'b0;
            ack_2_q      <= 1'b0;
            err_1_q      <= 1'b0;
            err_2_q      <= 1'b0;
            data_q       <= 16'h0000;
        end else begin
            ack_1_q <= 1'b0;
            ack_2_q <= 1'b0;
            err_1_q <= 1'b0;
            err_2_q <= 1'b0;
            lock_q  <= lock_q | lock_req_i;
            case (state_q)
                StIdle: begin
                    if (req_1_i || req_2_i) begin
                        last_grant_q <= win_d;
                        state_q      <= StGrant;
                    end
                end
                StGrant: begin
                    if (!blocked_d) begin
                        data_q <= win_data_d;
                        if (last_grant_q) ack_2_q <= 1'b1;
                        else              ack_1_q <= 1'b1;
                    end else begin
                        if (last_grant_q) err_2_q <= 1'b1;
                        else              err_1_q <= 1'b1;
                    end
                    state_q <= StResp;
                end
                StResp:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef CWE1234_DBG_UNLOCK_EN
    logic [7:0] dbg_cnt_q;

    // Debug window: correct key opens it for DBG_WINDOW cycles; a bad key locks out forever.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dbg_active_q <= 1'b0;
            dbg_fail_q   <= 1'b0;
            dbg_cnt_q    <= 8'd0;
        end else if (dbg_active_q) begin
            // Attempts while open are ignored: no extension, no failure.
            dbg_cnt_q <= dbg_cnt_q - 8'd1;
            if (dbg_cnt_q == 8'd1) dbg_active_q <= 1'b0;
        end else if (dbg_unlock_req_i && !dbg_fail_q) begin
            if (dbg_key_i == KEY) begin
                dbg_active_q <= 1'b1;
                dbg_cnt_q    <= DBG_WINDOW;
            end else begin
                dbg_fail_q <= 1'b1;
            end
        end
    end
`else
    logic unused_dbg;
    assign unused_dbg   = ^{dbg_unlock_req_i, dbg_key_i, KEY, DBG_WINDOW};
    assign dbg_active_q = 1'b0;
    assign dbg_fail_q   = 1'b0;
`endif

    assign ack_1_o       = ack_1_q;
    assign ack_2_o       = ack_2_q;
    assign err_1_o       = err_1_q;
    assign err_2_o       = err_2_q;
    assign lock_status_o = lock_q;
    assign dbg_active_o  = dbg_active_q;
    assign dbg_fail_o    = dbg_fail_q;
    assign data_out_o    = data_q;
    assign last_grant_o  = last_grant_q;

endmodule

// File: tb/tb_cwe1234_lock_arbiter.sv
// Self-checking bench for cwe1234_lock_arbiter; response pulses are checked
// against a scoreboard queue filled when each write is issued.
module tb_cwe1234_lock_arbiter;

`ifdef CWE1234_DBG_UNLOCK_EN
    localparam bit DbgEn = 1'b1;
`else
    localparam bit DbgEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_1 = 1'b0, req_2 = 1'b0;
    logic [15:0] data_1 = 16'h0, data_2 = 16'h0;
    logic        ack_1, ack_2, err_1, err_2;
    logic        lock_req = 1'b0;
    logic        lock_status;
    logic        dbg_unlock_req = 1'b0;
    logic [15:0] dbg_key = 16'h0;
    logic        dbg_active, dbg_fail;
    logic [15:0] data_out;
    logic        last_grant;

    typedef struct packed {
        logic [3:0]  resp;  // {ack_1, ack_2, err_1, err_2}
        logic [15:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_data = 16'h0;

    cwe1234_lock_arbiter dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .req_1_i          (req_1),
        .req_2_i          (req_2),
        .data_1_i         (data_1),
        .data_2_i         (data_2),
        .ack_1_o          (ack_1),
        .ack_2_o          (ack_2),
        .err_1_o          (err_1),
        .err_2_o          (err_2),
        .lock_req_i       (lock_req),
        .lock_status_o    (lock_status),
        .dbg_unlock_req_i (dbg_unlock_req),
        .dbg_key_i        (dbg_key),
        .dbg_active_o     (dbg_active),
        .dbg_fail_o       (dbg_fail),
        .data_out_o       (data_out),
        .last_grant_o     (last_grant)
    );

    always #5 clk = ~clk;

    // Response monitor: every ack/err pulse must match the head of the scoreboard.
    always @(posedge clk) begin
        #2;
        if (ack_1 || ack_2 || err_1 || err_2) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: got resp=%b data=%h, required no pulse",
                         {ack_1, ack_2, err_1, err_2}, data_out);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if ({ack_1, ack_2, err_1, err_2} !== e.resp || data_out !== e.data) begin
                    errors++;
                    $display("FAIL resp: got resp=%b data=%h, required resp=%b data=%h",
                             {ack_1, ack_2, err_1, err_2}, data_out, e.resp, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic exp_t make_exp(input int who, input bit ok, input logic [15:0] d);
        exp_t e;
        if (who == 1) e.resp = ok ? 4'b1000 : 4'b0010;
        else          e.resp = ok ? 4'b0100 : 4'b0001;
        e.data = ok ? d : exp_data;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single write starting in IDLE; req dropped in GRANT, optional lock pulse there.
    task automatic write1(input int who, input logic [15:0] d, input bit lock_pulse,
                          input bit ok);
        if (who == 1) begin req_1 = 1'b1; data_1 = d; end
        else          begin req_2 = 1'b1; data_2 = d; end
        step();  // now in GRANT
        req_1 = 1'b0;
        req_2 = 1'b0;
        lock_req = lock_pulse;
        sb_q.push_back(make_exp(who, ok, d));
        if (ok) exp_data = d;
        step();  // now in RESP, response visible
        lock_req = 1'b0;
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL latency_w%0d: pending=%0d, required 0 two cycles after request",
                     who, sb_q.size());
            sb_q.delete();
        end
        #(-3 + 10);  // wait up to next edge region
        @(posedge clk);
        #1;  // back in IDLE
    endtask

    task automatic dbg_pulse(input logic [15:0] key);
        dbg_unlock_req = 1'b1;
        dbg_key = key;
        step();
        dbg_unlock_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_data = 16'h0;
        checks++;
        if ({data_out, lock_status, last_grant, dbg_active, dbg_fail, ack_1, ack_2, err_1,
             err_2} !== {16'h0, 1'b0, 1'b1, 6'b0}) begin
            errors++;
            $display("FAIL reset_state: got data=%h lock=%b lg=%b dbga=%b dbgf=%b, required 0000 0 1 0 0",
                     data_out, lock_status, last_grant, dbg_active, dbg_fail);
        end
    endtask

    task automatic test_basic_write();
        write1(1, 16'h1234, 1'b0, 1'b1);
        checks++;
        if (last_grant !== 1'b0 || data_out !== 16'h1234) begin
            errors++;
            $display("FAIL basic_write: got lg=%b data=%h, required 0 1234", last_grant, data_out);
        end
    endtask

    task automatic test_back_to_back();
        test_reset();
        req_1 = 1'b1; data_1 = 16'h1111;
        req_2 = 1'b1; data_2 = 16'h2222;
        for (int k = 0; k < 4; k++) begin
            logic [15:0] d;
            d = (k % 2 == 0) ? 16'h1111 : 16'h2222;
            sb_q.push_back(make_exp((k % 2 == 0) ? 1 : 2, 1'b1, d));
            exp_data = d;
        end
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #3;
            if (i % 3 == 2) begin
                checks++;
                if (sb_q.size() != 4 - (i + 1) / 3) begin
                    errors++;
                    $display("FAIL alternate_cadence: cycle %0d pending=%0d, required %0d",
                             i, sb_q.size(), 4 - (i + 1) / 3);
                end
            end
        end
        req_1 = 1'b0;
        req_2 = 1'b0;
        step();
    endtask

    task automatic test_lock();
        write1(2, 16'hBEEF, 1'b1, 1'b0);
        checks++;
        if (lock_status !== 1'b1 || data_out !== 16'h2222) begin
            errors++;
            $display("FAIL lock_set: got lock=%b data=%h, required 1 2222", lock_status, data_out);
        end
        write1(1, 16'h5555, 1'b0, 1'b0);
    endtask

    task automatic test_dbg_unlock();
        dbg_pulse(16'hA5C3);  // edge E0
        checks++;
        if (dbg_active !== DbgEn) begin
            errors++;
            $display("FAIL dbg_open: got dbg_active=%b, required %b", dbg_active, DbgEn);
        end
        write1(1, 16'h0F0F, 1'b0, DbgEn);  // E0+3
        dbg_pulse(16'h0000);               // E0+4, ignored while open
        repeat (11) step();                // E0+15
        checks++;
        if (dbg_active !== DbgEn || dbg_fail !== 1'b0) begin
            errors++;
            $display("FAIL dbg_window_last: got a=%b f=%b, required a=%b f=0",
                     dbg_active, dbg_fail, DbgEn);
        end
        step();                            // E0+16
        checks++;
        if (dbg_active !== 1'b0 || dbg_fail !== 1'b0) begin
            errors++;
            $display("FAIL dbg_window_closed: got a=%b f=%b, required 0 0", dbg_active, dbg_fail);
        end
        write1(1, 16'hCAFE, 1'b0, 1'b0);
    endtask

    task automatic test_dbg_fail();
        dbg_pulse(16'h0000);
        checks++;
        if (dbg_fail !== DbgEn || dbg_active !== 1'b0) begin
            errors++;
            $display("FAIL dbg_bad_key: got f=%b a=%b, required f=%b a=0", dbg_fail, dbg_active, DbgEn);
        end
        dbg_pulse(16'hA5C3);
        checks++;
        if (dbg_active !== 1'b0 || dbg_fail !== DbgEn) begin
            errors++;
            $display("FAIL dbg_lockout: got a=%b f=%b, required a=0 f=%b", dbg_active, dbg_fail, DbgEn);
        end
        write1(2, 16'h3333, 1'b0, 1'b0);
        write1(1, 16'h4444, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        req_1 = 1'b1;
        data_1 = 16'h7777;
        step();  // GRANT
        req_1 = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_data = 16'h0;
        checks++;
        if (data_out !== 16'h0 || lock_status !== 1'b0 || ack_1 !== 1'b0 || dbg_fail !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got data=%h lock=%b ack1=%b, required 0000 0 0",
                     data_out, lock_status, ack_1);
        end
        repeat (4) step();
        write1(2, 16'h9999, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_back_to_back();
        test_lock();
        test_dbg_unlock();
        test_dbg_fail();
        test_reset_mid();
        repeat (3) step();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d, required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
